eth_pcs_rx_block_lock: RTL and testbench

Block-lock controller for the 10GBASE-R receive path, per the Clause 49 lock state machine. It inspects each 2-bit sync header from the RX gearbox and drives single-cycle slip requests back to the gearbox until 64/66 block alignment is found. It asserts block lock after SH_VAL_TH consecutive valid headers, and drops lock when SH_INVAL_TH invalid headers fall inside one SH_VAL_TH-header window. It sits between the RX gearbox and the descrambler/decoder; o_block_lock gates downstream decode.

---
 rtl/eth_pcs_rx_block_lock.sv | 163 ++++++++++++++++
 tb/tb_eth_pcs_rx_block_lock.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_rx_block_lock.sv
// 10GBASE-R receive block-lock controller: hunts for 64/66 alignment by slipping
// the gearbox on bad sync headers, then holds lock until too many headers go bad.
module eth_pcs_rx_block_lock #(
  parameter int SH_VAL_TH   = 64,
  parameter int SH_INVAL_TH = 16,
  parameter int SLIP_WAIT   = 2,
  parameter int W_SYNC      = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_signal_ok,
  input  logic              i_hdr_valid,
  input  logic [W_SYNC-1:0] i_sync_hdr,
  output logic              o_slip,
  output logic              o_block_lock,
  output logic              o_lock_lost,
  output logic [1:0]        o_dbg_state
);

  // Handshake: i_hdr_valid is a one-cycle strobe with no back-pressure; a header
  // is consumed on every clock edge where i_hdr_valid=1. o_slip is a request
  // pulse the gearbox must act on; there is no acknowledge.

  localparam int SH_W  = $clog2(SH_VAL_TH) + 1;
  localparam int INV_W = $clog2(SH_INVAL_TH) + 1;
  localparam int WT_W  = 4;

  localparam logic [SH_W-1:0]  SH_MAX   = SH_W'(SH_VAL_TH);
  localparam logic [INV_W-1:0] INV_MAX  = INV_W'(SH_INVAL_TH);
  localparam logic [WT_W-1:0]  WAIT_MAX = WT_W'(SLIP_WAIT);

  typedef enum logic [1:0] {
    ST_LOCK_INIT = 2'd0,
    ST_TEST_SH   = 2'd1,
    ST_SLIP_WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SH_W-1:0]    sh_cnt_q, sh_cnt_d, sh_nxt;
  logic [INV_W-1:0]   inv_cnt_q, inv_cnt_d, inv_nxt;
  logic [WT_W-1:0]    wait_cnt_q, wait_cnt_d, wait_nxt;
  logic               slip_q, slip_d;
  logic               lock_q, lock_d;
  logic               lost_q, lost_d;
  logic               hdr_ok;

  assign hdr_ok = (i_sync_hdr == W_SYNC'(1)) || (i_sync_hdr == W_SYNC'(2));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_LOCK_INIT;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      wait_cnt_q <= '0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      slip_q     <= slip_d;
      lock_q     <= lock_d;
      lost_q     <= lost_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    slip_d     = 1'b0;
    lock_d     = lock_q;
    lost_d     = 1'b0;
    sh_nxt     = sh_cnt_q + SH_W'(1);
    inv_nxt    = inv_cnt_q + (hdr_ok ? INV_W'(0) : INV_W'(1));
    wait_nxt   = wait_cnt_q + WT_W'(1);

    if (!i_signal_ok) begin
      state_d    = ST_LOCK_INIT;
      sh_cnt_d   = '0;
      inv_cnt_d  = '0;
      wait_cnt_d = '0;
      lock_d     = 1'b0;
      lost_d     = lock_q;
    end else begin
      case (state_q)
        ST_LOCK_INIT: begin
          state_d    = ST_TEST_SH;
          sh_cnt_d   = '0;
          inv_cnt_d  = '0;
          wait_cnt_d = '0;
        end

        ST_TEST_SH: begin
          if (i_hdr_valid) begin
            if (!lock_q) begin
              if (!hdr_ok) begin
                slip_d    = 1'b1;
                sh_cnt_d  = '0;
                inv_cnt_d = '0;
                state_d   = ST_SLIP_WAIT;
              end else if (sh_nxt == SH_MAX) begin
                lock_d    = 1'b1;
                sh_cnt_d  = '0;
                inv_cnt_d = '0;
              end else begin
                sh_cnt_d = sh_nxt;
              end
            end else begin
              // Loss of lock wins over a window that closes on the same header.
              if (inv_nxt == INV_MAX) begin
                lock_d    = 1'b0;
                lost_d    = 1'b1;
                slip_d    = 1'b1;
                sh_cnt_d  = '0;
                inv_cnt_d = '0;
                state_d   = ST_SLIP_WAIT;
              end else if (sh_nxt == SH_MAX) begin
                sh_cnt_d  = '0;
                inv_cnt_d = '0;
              end else begin
                sh_cnt_d  = sh_nxt;
                inv_cnt_d = inv_nxt;
              end
            end
          end
        end

        ST_SLIP_WAIT: begin
          // Exactly SLIP_WAIT strobes are discarded while the gearbox realigns.
          if (WAIT_MAX == '0) begin
            state_d    = ST_TEST_SH;
            wait_cnt_d = '0;
          end else if (i_hdr_valid) begin
            if (wait_nxt == WAIT_MAX) begin
              state_d    = ST_TEST_SH;
              wait_cnt_d = '0;
            end else begin
              wait_cnt_d = wait_nxt;
            end
          end
        end

        default: begin
          state_d    = ST_LOCK_INIT;
          sh_cnt_d   = '0;
          inv_cnt_d  = '0;
          wait_cnt_d = '0;
          lock_d     = 1'b0;
        end
      endcase
    end
  end

  assign o_slip       = slip_q;
  assign o_block_lock = lock_q;
  assign o_lock_lost  = lost_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_eth_pcs_rx_block_lock.sv
// Directed bench for eth_pcs_rx_block_lock: lock acquisition, slip hunting,
// windowed loss of lock, signal loss, gapped strobes and reset mid-slip.
module tb_eth_pcs_rx_block_lock;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_signal_ok;
  logic       i_hdr_valid;
  logic [1:0] i_sync_hdr;
  logic       o_slip;
  logic       o_block_lock;
  logic       o_lock_lost;
  logic [1:0] o_dbg_state;

  int n_vec;
  int n_err;
  logic prev_slip;

  eth_pcs_rx_block_lock dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_signal_ok  (i_signal_ok),
    .i_hdr_valid  (i_hdr_valid),
    .i_sync_hdr   (i_sync_hdr),
    .o_slip       (o_slip),
    .o_block_lock (o_block_lock),
    .o_lock_lost  (o_lock_lost),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle from a negedge; on return, outputs reflect that cycle.
  task automatic step(input logic v, input logic [1:0] h);
    i_hdr_valid = v;
    i_sync_hdr  = h;
    @(negedge i_clk);
    chk("slip_consecutive", {7'd0, o_slip & prev_slip}, 8'd0);
    chk("slip_while_locked", {7'd0, o_slip & o_block_lock}, 8'd0);
    prev_slip = o_slip;
  endtask

  task automatic send_valid(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 2'b01);
  endtask

  // 63 valid headers must not lock, the 64th must.
  task automatic acquire(input string tag);
    send_valid(63);
    chk({tag, "_pre"}, {7'd0, o_block_lock}, 8'd0);
    step(1'b1, 2'b10);
    chk({tag, "_lock"}, {7'd0, o_block_lock}, 8'd1);
    chk({tag, "_noslip"}, {7'd0, o_slip}, 8'd0);
  endtask

  task automatic chk_outs(input string tag, input logic s, input logic l, input logic x);
    chk({tag, "_slip"}, {7'd0, o_slip}, {7'd0, s});
    chk({tag, "_lock"}, {7'd0, o_block_lock}, {7'd0, l});
    chk({tag, "_lost"}, {7'd0, o_lock_lost}, {7'd0, x});
  endtask

  int slips;
  int losts;
  int strobes;

  initial begin
    n_vec = 0; n_err = 0; prev_slip = 1'b0;
    i_rst_n = 1'b0; i_signal_ok = 1'b1; i_hdr_valid = 1'b0; i_sync_hdr = 2'b00;
    @(negedge i_clk);
    step(1'b1, 2'b11);
    step(1'b1, 2'b00);
    chk_outs("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_state", {6'd0, o_dbg_state}, 8'd0);

    // first lock: one idle cycle leaves LOCK_INIT, then 64 valid headers
    i_rst_n = 1'b1;
    step(1'b0, 2'b00);
    acquire("lock1");

    // 15 invalid headers in a window keep lock
    losts = 0; slips = 0;
    for (int j = 0; j < 64; j++) begin
      step(1'b1, ((j % 4 == 0) && (j < 60)) ? 2'b00 : 2'b01);
      losts += int'(o_lock_lost); slips += int'(o_slip);
    end
    chk("w15_lock", {7'd0, o_block_lock}, 8'd1);
    chk("w15_lost_cnt", 8'(losts), 8'd0);
    chk("w15_slip_cnt", 8'(slips), 8'd0);

    // 16 invalid headers: 16th at header 61 of the window
    for (int j = 0; j < 61; j++) begin
      step(1'b1, (j % 4 == 0) ? 2'b11 : 2'b10);
      if (j == 59) chk("w16_hold", {7'd0, o_block_lock}, 8'd1);
    end
    chk_outs("w16_loss", 1'b1, 1'b0, 1'b1);

    // two ignored strobes after the slip, then relock
    step(1'b1, 2'b00);
    chk_outs("w16_wait1", 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11);
    chk("w16_wait2", {7'd0, o_slip}, 8'd0);
    acquire("relock1");

    // 16th invalid lands on the 64th header: loss wins over window reset
    for (int j = 0; j < 64; j++) step(1'b1, (j % 4 == 3) ? 2'b00 : 2'b01);
    chk_outs("edge_loss", 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);

    // unlocked: bad header at strobe 10
    send_valid(9);
    chk("hunt_pre", {7'd0, o_slip}, 8'd0);
    step(1'b1, 2'b11);
    chk_outs("hunt_slip", 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b11);
    chk("hunt_ign1", {7'd0, o_slip}, 8'd0);
    step(1'b1, 2'b00);
    chk("hunt_ign2", {7'd0, o_slip}, 8'd0);
    acquire("relock2");

    // signal loss while locked
    i_signal_ok = 1'b0;
    step(1'b1, 2'b01);
    chk_outs("sig_drop", 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'b01);
    chk_outs("sig_low", 1'b0, 1'b0, 1'b0);
    i_signal_ok = 1'b1;
    step(1'b0, 2'b00);
    acquire("relock3");

    // gapped strobes: every 33rd cycle idle
    i_signal_ok = 1'b0;
    step(1'b0, 2'b00);
    i_signal_ok = 1'b1;
    step(1'b0, 2'b00);
    strobes = 0;
    for (int c = 0; (strobes < 64) && (c < 200); c++) begin
      if (c % 33 == 32) begin
        step(1'b0, 2'b01);
        chk("gap_idle", {7'd0, o_block_lock}, 8'd0);
      end else begin
        step(1'b1, 2'b01);
        strobes++;
        if (strobes == 63) chk("gap_pre", {7'd0, o_block_lock}, 8'd0);
      end
    end
    chk("gap_lock", {7'd0, o_block_lock}, 8'd1);

    // reset while waiting after a slip
    i_signal_ok = 1'b0;
    step(1'b0, 2'b00);
    i_signal_ok = 1'b1;
    step(1'b0, 2'b00);
    step(1'b1, 2'b00);
    chk("rst_mid_slip", {7'd0, o_slip}, 8'd1);
    i_rst_n = 1'b0;
    step(1'b1, 2'b00);
    chk_outs("rst_mid", 1'b0, 1'b0, 1'b0);
    chk("rst_mid_state", {6'd0, o_dbg_state}, 8'd0);
    i_rst_n = 1'b1;
    step(1'b0, 2'b00);
    acquire("relock4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
